// File: rtl/issue_scoreboard.sv
// Issue scoreboard: tracks in-flight register writes with per-register
// pending counters, stalls decode on RAW hazards or counter saturation,
// and supports a drain handshake that empties the pipeline before holding.
module issue_scoreboard (
  input  logic       clk2,
  input  logic       rst_n,
  input  logic       id_valid,
  input  logic [2:0] id_rs1,
  input  logic       id_rs1_use,
  input  logic [2:0] id_rs2,
  input  logic       id_rs2_use,
  input  logic [2:0] id_rd,
  input  logic       id_RegWrite,
  input  logic       wb_RegWrite,
  input  logic [2:0] wb_regwradd,
  input  logic       drain_req,
  output logic       issue,
  output logic       stall,
  output logic [7:0] busy,
  output logic       drain_done,
  output logic       sb_err
);

  typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;

  state_t     state_q, state_d;
  logic [1:0] cnt_q [8];
  logic [1:0] cnt_d [8];
  logic       sb_err_q, sb_err_d;
  logic [7:0] inc;
  logic [7:0] dec;
  logic       hazard;
  logic       full;
  logic       all_zero;

  // Busy view of the registered counters; the drain condition is all-clear
  always_comb begin
    busy = 8'h00;
    for (int r = 0; r < 8; r++) begin
      busy[r] = (cnt_q[r] != 2'd0);
    end
    all_zero = (busy == 8'h00);
  end

  // Hazard and saturation checks see only registered counts, never same-cycle releases
  always_comb begin
    hazard = id_valid & ((id_rs1_use & (cnt_q[id_rs1] != 2'd0)) |
                         (id_rs2_use & (cnt_q[id_rs2] != 2'd0)));
    full   = id_valid & id_RegWrite & (cnt_q[id_rd] == 2'd3);
  end

  // Per-register increment (issued write) and decrement (writeback) strobes
  always_comb begin
    inc = 8'h00;
    dec = 8'h00;
    for (int r = 0; r < 8; r++) begin
      inc[r] = issue & id_RegWrite & (id_rd == 3'(r));
      dec[r] = wb_RegWrite & (wb_regwradd == 3'(r));
    end
  end

  // Counter update; a release with nothing pending holds at zero and flags a fault
  always_comb begin
    sb_err_d = sb_err_q;
    for (int r = 0; r < 8; r++) begin
      cnt_d[r] = cnt_q[r];
      if (inc[r] && !dec[r]) begin
        cnt_d[r] = cnt_q[r] + 2'd1;
      end else if (dec[r] && !inc[r]) begin
        if (cnt_q[r] == 2'd0) begin
          sb_err_d = 1'b1;
        end else begin
          cnt_d[r] = cnt_q[r] - 2'd1;
        end
      end
    end
  end

  // Counter and sticky error registers
  always_ff @(posedge clk2 or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < 8; r++) begin
        cnt_q[r] <= 2'd0;
      end
      sb_err_q <= 1'b0;
    end else begin
      for (int r = 0; r < 8; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
      sb_err_q <= sb_err_d;
    end
  end

  // Drain FSM state register
  always_ff @(posedge clk2 or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Drain FSM next state; once draining, the drain always runs to completion
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (drain_req) state_d = DRAIN;
      DRAIN:   if (all_zero) state_d = DONE;
      DONE:    if (!drain_req) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // Decode handshake outputs; issue is combinational and only possible in RUN
  always_comb begin
    stall      = id_valid & (hazard | full | (state_q != RUN));
    issue      = id_valid & ~stall;
    drain_done = (state_q == DONE);
    sb_err     = sb_err_q;
  end

endmodule

// File: tb/tb_issue_scoreboard.sv
// Self-checking bench for issue_scoreboard: a stimulus process drives
// directed scenarios and random traffic, predicting outputs from a
// behavioural model into a queue; a monitor pops and compares each cycle.
module tb_issue_scoreboard;

  logic       clk2;
  logic       rst_n;
  logic       id_valid;
  logic [2:0] id_rs1;
  logic       id_rs1_use;
  logic [2:0] id_rs2;
  logic       id_rs2_use;
  logic [2:0] id_rd;
  logic       id_RegWrite;
  logic       wb_RegWrite;
  logic [2:0] wb_regwradd;
  logic       drain_req;
  logic       issue;
  logic       stall;
  logic [7:0] busy;
  logic       drain_done;
  logic       sb_err;

  typedef struct {
    logic       issue;
    logic       stall;
    logic [7:0] busy;
    logic       drainDone;
    logic       err;
  } expect_t;

  expect_t expQueue[$];

  int checks = 0;
  int errors = 0;

  // Reference model: pending write counts per register and drain mode
  localparam int MODE_RUN   = 0;
  localparam int MODE_DRAIN = 1;
  localparam int MODE_DONE  = 2;
  int pend [8];
  int mode;
  bit errFlag;

  issue_scoreboard dut (
    .clk2        (clk2),
    .rst_n       (rst_n),
    .id_valid    (id_valid),
    .id_rs1      (id_rs1),
    .id_rs1_use  (id_rs1_use),
    .id_rs2      (id_rs2),
    .id_rs2_use  (id_rs2_use),
    .id_rd       (id_rd),
    .id_RegWrite (id_RegWrite),
    .wb_RegWrite (wb_RegWrite),
    .wb_regwradd (wb_regwradd),
    .drain_req   (drain_req),
    .issue       (issue),
    .stall       (stall),
    .busy        (busy),
    .drain_done  (drain_done),
    .sb_err      (sb_err)
  );

  // Free-running clock, 10 time units per period
  initial begin
    clk2 = 1'b0;
    forever #5 clk2 = ~clk2;
  end

  task automatic modelReset();
    for (int r = 0; r < 8; r++) pend[r] = 0;
    mode    = MODE_RUN;
    errFlag = 1'b0;
  endtask

  // Outputs the model predicts for the currently driven inputs
  function automatic expect_t modelExpect();
    expect_t e;
    bit hz, fl, st;
    hz = id_valid && ((id_rs1_use && pend[id_rs1] > 0) || (id_rs2_use && pend[id_rs2] > 0));
    fl = id_valid && id_RegWrite && (pend[id_rd] == 3);
    st = id_valid && (hz || fl || mode != MODE_RUN);
    e.issue = id_valid && !st;
    e.stall = st;
    e.busy  = 8'h00;
    for (int r = 0; r < 8; r++) e.busy[r] = (pend[r] > 0);
    e.drainDone = (mode == MODE_DONE);
    e.err       = errFlag;
    return e;
  endfunction

  // Advance the model across one clock edge given the inputs of that cycle
  task automatic modelStep(input bit issued);
    bit anyPending;
    anyPending = 1'b0;
    for (int r = 0; r < 8; r++) if (pend[r] > 0) anyPending = 1'b1;
    for (int r = 0; r < 8; r++) begin
      bit up, down;
      up   = issued && id_RegWrite && (id_rd == r);
      down = wb_RegWrite && (wb_regwradd == r);
      if (up && !down) pend[r] = pend[r] + 1;
      else if (down && !up) begin
        if (pend[r] == 0) errFlag = 1'b1;
        else pend[r] = pend[r] - 1;
      end
    end
    if (mode == MODE_RUN && drain_req) mode = MODE_DRAIN;
    else if (mode == MODE_DRAIN && !anyPending) mode = MODE_DONE;
    else if (mode == MODE_DONE && !drain_req) mode = MODE_RUN;
  endtask

  // One clock cycle of stimulus; called at posedge+1, returns at next posedge+1
  task automatic applyStimulus(input logic v, input logic [2:0] rs1, input logic u1,
                               input logic [2:0] rs2, input logic u2,
                               input logic [2:0] rd, input logic w,
                               input logic wbw, input logic [2:0] wba,
                               input logic dr, input bit doReset);
    expect_t e;
    id_valid = v; id_rs1 = rs1; id_rs1_use = u1; id_rs2 = rs2; id_rs2_use = u2;
    id_rd = rd; id_RegWrite = w; wb_RegWrite = wbw; wb_regwradd = wba; drain_req = dr;
    if (doReset) begin
      #1;
      rst_n = 1'b0;
      modelReset();
    end
    e = modelExpect();
    expQueue.push_back(e);
    if (doReset) begin
      #5;
      rst_n = 1'b1;
    end
    @(posedge clk2);
    modelStep(e.issue);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares DUT outputs against the oldest prediction mid-cycle
  initial begin
    expect_t e;
    forever begin
      @(negedge clk2);
      if (expQueue.size() > 0) begin
        e = expQueue.pop_front();
        checkOutput("issue",      {7'd0, issue},      {7'd0, e.issue});
        checkOutput("stall",      {7'd0, stall},      {7'd0, e.stall});
        checkOutput("busy",       busy,               e.busy);
        checkOutput("drain_done", {7'd0, drain_done}, {7'd0, e.drainDone});
        checkOutput("sb_err",     {7'd0, sb_err},     {7'd0, e.err});
      end
    end
  end

  // Idle cycle helper with an optional writeback and drain request
  task automatic idleCycle(input logic wbw, input logic [2:0] wba, input logic dr);
    applyStimulus(1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, wbw, wba, dr, 1'b0);
  endtask

  // Directed scenarios followed by constrained-random traffic
  initial begin
    logic [2:0] wbAddr;
    logic       drainNow;
    logic       wbNow;
    int         start;

    rst_n = 1'b0;
    id_valid = 0; id_rs1 = 0; id_rs1_use = 0; id_rs2 = 0; id_rs2_use = 0;
    id_rd = 0; id_RegWrite = 0; wb_RegWrite = 0; wb_regwradd = 0; drain_req = 0;
    modelReset();
    @(posedge clk2);
    #1;

    // Reset state, with a valid instruction presented while in reset
    applyStimulus(1'b1, 3'd1, 1'b1, 3'd2, 1'b1, 3'd3, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1);
    idleCycle(1'b1, 3'd3, 1'b0);
    applyStimulus(1'b1, 3'd3, 1'b1, 3'd0, 1'b0, 3'd1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1);

    // RAW stall then release through writeback
    applyStimulus(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd3, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
    applyStimulus(1'b1, 3'd3, 1'b1, 3'd0, 1'b0, 3'd1, 1'b0, 1'b1, 3'd3, 1'b0, 1'b0);
    applyStimulus(1'b1, 3'd3, 1'b1, 3'd0, 1'b0, 3'd1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    // rs2 hazard path
    applyStimulus(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd7, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
    applyStimulus(1'b1, 3'd7, 1'b0, 3'd7, 1'b1, 3'd1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    idleCycle(1'b1, 3'd7, 1'b0);

    // Saturation on r5
    repeat (3) applyStimulus(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd5, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
    applyStimulus(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd5, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
    applyStimulus(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd5, 1'b1, 1'b1, 3'd5, 1'b0, 1'b0);
    repeat (3) idleCycle(1'b1, 3'd5, 1'b0);

    // Simultaneous issue and retire of r2
    applyStimulus(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd2, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
    applyStimulus(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd2, 1'b1, 1'b1, 3'd2, 1'b0, 1'b0);
    idleCycle(1'b0, 3'd0, 1'b0);
    idleCycle(1'b1, 3'd2, 1'b0);

    // Underflow on r6 sets a sticky error
    idleCycle(1'b1, 3'd6, 1'b0);
    repeat (2) idleCycle(1'b0, 3'd0, 1'b0);

    // Drain with two writes in flight; the first drain cycle still issues
    applyStimulus(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd4, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
    applyStimulus(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd5, 1'b1, 1'b0, 3'd0, 1'b1, 1'b0);
    applyStimulus(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd1, 1'b0, 1'b1, 3'd4, 1'b0, 1'b0);
    applyStimulus(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd1, 1'b0, 1'b1, 3'd5, 1'b1, 1'b0);
    applyStimulus(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd1, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0);
    applyStimulus(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd1, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0);
    applyStimulus(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    applyStimulus(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd1, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
    idleCycle(1'b1, 3'd1, 1'b0);

    // Asynchronous reset in the middle of a drain
    applyStimulus(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd4, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
    applyStimulus(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd5, 1'b1, 1'b0, 3'd0, 1'b1, 1'b0);
    idleCycle(1'b0, 3'd0, 1'b1);
    applyStimulus(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd4, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1);
    applyStimulus(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd6, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
    idleCycle(1'b1, 3'd6, 1'b0);

    // Random traffic, writebacks biased toward registers with pending writes
    drainNow = 1'b0;
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 9) == 0) drainNow = ~drainNow;
      wbNow  = ($urandom_range(0, 2) != 0);
      wbAddr = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 15) != 0) begin
        start = $urandom_range(0, 7);
        for (int k = 7; k >= 0; k--) begin
          if (pend[(start + k) % 8] > 0) wbAddr = 3'((start + k) % 8);
        end
      end
      applyStimulus(($urandom_range(0, 3) != 0),
                    3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                    3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                    3'($urandom_range(0, 7)), ($urandom_range(0, 3) != 0),
                    wbNow, wbAddr, drainNow, ($urandom_range(0, 99) == 0));
    end

    idleCycle(1'b0, 3'd0, 1'b0);
    @(negedge clk2);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
